// File: rtl/decoder_3x8_grant.sv
// Replays buffered {Y,z} codes as registered one-hot grants with hold/gap timing.
// Optional sticky overflow flag on port ovf when DECODER_OVF_EN is defined.
module decoder_3x8_grant #(
    parameter int HOLD  = 4,
    parameter int GAP   = 1,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] Y,
    input  logic       z,
`ifdef DECODER_OVF_EN
    output logic       ovf,
`endif
    output logic       ready,
    output logic [7:0] W,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [7:0]    w_q, w_d;
    logic          busy_q, busy_d;
    logic          push, pop;
    logic [2:0]    head;

    assign ready = (count_q != (AW+1)'(DEPTH));
    assign push  = z && ready;
    assign head  = mem_q[rd_ptr_q];
    assign W     = w_q;
    assign busy  = busy_q;

    always_comb begin
        pop     = 1'b0;
        state_d = state_q;
        hcnt_d  = hcnt_q;
        gcnt_d  = gcnt_q;
        w_d     = w_q;
        unique case (state_q)
            ST_IDLE: begin
                w_d = 8'h00;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    w_d     = 8'd1 << head;
                    hcnt_d  = HW'(HOLD - 1);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - 1'b1;
                end else begin
                    w_d = 8'h00;
                    if (GAP > 0) begin
                        gcnt_d  = GW'(GAP - 1);
                        state_d = ST_GAP;
                    end else if (count_q != '0) begin
                        // zero-gap mode chains grants straight from the FIFO
                        pop    = 1'b1;
                        w_d    = 8'd1 << head;
                        hcnt_d = HW'(HOLD - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                w_d = 8'h00;
                if (gcnt_q != '0) gcnt_d = gcnt_q - 1'b1;
                else              state_d = ST_IDLE;
            end
            default: begin
                w_d     = 8'h00;
                state_d = ST_IDLE;
            end
        endcase
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        busy_d  = (state_d != ST_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= Y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            hcnt_q   <= '0;
            gcnt_q   <= '0;
            w_q      <= 8'h00;
            busy_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            gcnt_q  <= gcnt_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
        end
    end

`ifdef DECODER_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
    always_ff @(posedge clk) begin
        if (reset)            ovf_q <= 1'b0;
        else if (z && !ready) ovf_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_decoder_3x8_grant.sv
// Scoreboard bench for decoder_3x8_grant: directed steps plus a grant monitor.
// Define DECODER_OVF_EN to also check the sticky overflow flag.
module tb_decoder_3x8_grant;

    localparam int HOLD  = 4;
    localparam int GAP   = 1;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] Y;
    logic       z;
    logic       ready;
    logic [7:0] W;
    logic       busy;
`ifdef DECODER_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q [$];
    bit b2b = 1'b0;

    decoder_3x8_grant #(.HOLD(HOLD), .GAP(GAP), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .Y     (Y),
        .z     (z),
`ifdef DECODER_OVF_EN
        .ovf   (ovf),
`endif
        .ready (ready),
        .W     (W),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] code, input bit accepted);
        Y = code;
        z = 1'b1;
        if (accepted) exp_q.push_back(code);
        tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (busy === 1'b0) break;
            tick();
        end
        check("idle_timeout", busy, 0);
    endtask

    // Grant monitor: code order, one-hot, hold length, inter-grant gap
    bit         in_g = 1'b0;
    bit         have_prev = 1'b0;
    logic [7:0] cur;
    int         run, zrun;

    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            in_g = 1'b0;
            have_prev = 1'b0;
            run = 0;
            zrun = 0;
        end else begin
            check("onehot", {31'd0, $countones(W) <= 1}, 1);
            if (W != 8'h00) begin
                if (!in_g || W != cur) begin
                    if (in_g) check("hold_len", run, HOLD);
                    if (b2b && have_prev)
                        check("gap_len", zrun, GAP + 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", W, 0);
                    end else begin
                        logic [2:0] e;
                        e = exp_q.pop_front();
                        check("grant_code", W, 8'd1 << e);
                    end
                    in_g = 1'b1;
                    cur = W;
                    run = 1;
                end else begin
                    run++;
                end
            end else begin
                if (in_g) begin
                    check("hold_len", run, HOLD);
                    in_g = 1'b0;
                    have_prev = 1'b1;
                    zrun = 0;
                end
                zrun++;
            end
            if (!b2b) have_prev = 1'b0;
        end
    end

    initial begin
        reset = 1'b1;
        z = 1'b0;
        Y = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_W", W, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 1);
`ifdef DECODER_OVF_EN
        check("rst_ovf", ovf, 0);
`endif

        // single code: latency, hold, gap, busy fall
        push(3'd5, 1'b1);
        z = 1'b0;
        check("t1_latency_W", W, 8'h00);
        check("t1_busy", busy, 1);
        for (int i = 0; i < HOLD; i++) begin
            tick();
            check("t1_W_hold", W, 8'h20);
            check("t1_ready", ready, 1);
        end
        tick();
        check("t1_W_gap", W, 8'h00);
        check("t1_busy_gap", busy, 1);
        tick();
        check("t1_W_idle", W, 8'h00);
        check("t1_busy_idle", busy, 0);
        tick();

        // back-to-back codes with a repeat
        b2b = 1'b1;
        push(3'd7, 1'b1);
        push(3'd0, 1'b1);
        push(3'd3, 1'b1);
        push(3'd3, 1'b1);
        z = 1'b0;
        check("t2_busy", busy, 1);
        wait_idle();
        check("t2_drained", exp_q.size(), 0);
        b2b = 1'b0;
        tick();

        // fill while the first grant stalls the FIFO
        b2b = 1'b1;
        push(3'd1, 1'b1);
        push(3'd2, 1'b1);
        push(3'd6, 1'b1);
        push(3'd4, 1'b1);
        push(3'd1, 1'b1);
        check("t3_full", ready, 0);
        push(3'd7, 1'b0);
        z = 1'b0;
        check("t3_still_full", ready, 0);
`ifdef DECODER_OVF_EN
        check("t3_ovf", ovf, 1);
`endif
        wait_idle();
        check("t3_drained", exp_q.size(), 0);
        check("t3_ready", ready, 1);
`ifdef DECODER_OVF_EN
        check("t3_ovf_sticky", ovf, 1);
`endif
        b2b = 1'b0;
        tick();

        // reset in the 2nd cycle of a grant with 2 codes queued
        push(3'd3, 1'b1);
        push(3'd5, 1'b1);
        push(3'd6, 1'b1);
        z = 1'b0;
        check("t4_W_mid", W, 8'h08);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("t4_W_rst", W, 8'h00);
        check("t4_ready_rst", ready, 1);
        check("t4_busy_rst", busy, 0);
        tick();
        reset = 1'b0;
`ifdef DECODER_OVF_EN
        check("t4_ovf_clr", ovf, 0);
`endif
        for (int i = 0; i < 20; i++) tick();
        check("t4_W_quiet", W, 8'h00);
        check("t4_busy_quiet", busy, 0);

        // z low: Y sweep must be ignored
        for (int i = 0; i < 8; i++) begin
            Y = 3'(i);
            z = 1'b0;
            tick();
            check("t5_W", W, 8'h00);
            check("t5_busy", busy, 0);
        end
        tick();
        check("t5_W_after", W, 8'h00);
        check("t5_ready", ready, 1);

        // push at the pop edge with two queued
        b2b = 1'b1;
        push(3'd0, 1'b1);
        push(3'd2, 1'b1);
        push(3'd4, 1'b1);
        z = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t6_W_pre", W, 8'h00);
        push(3'd5, 1'b1);
        check("t6_W_pop", W, 8'h04);
        check("t6_ready2", ready, 1);
        push(3'd7, 1'b1);
        check("t6_ready3", ready, 1);
        push(3'd1, 1'b1);
        z = 1'b0;
        check("t6_ready4", ready, 0);
        wait_idle();
        check("t6_drained", exp_q.size(), 0);
        b2b = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
